// File: rtl/boid_pkg.sv
// Shared constants and state encoding for the boid display pipeline.
// Display geometry, boid limits and the frame scheduler state type.
package boid_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int MAX_BOIDS    = 16;
  localparam int PIX_ADDR_W   = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

endpackage

// File: rtl/boid_frame_scheduler.sv
// Per-frame rebuild of the boid display RAM: clear, scan every BPU, write.
// Define BOID_SCHED_DOUBLE_BUFFER_EN to flip buf_sel on each new frame.
module boid_frame_scheduler #(
  parameter int NUM_BOIDS   = boid_pkg::MAX_BOIDS,
  parameter int SEL_W       = $clog2(NUM_BOIDS),
  parameter int ADDR_W      = boid_pkg::PIX_ADDR_W,
  parameter int PIXEL_COUNT = boid_pkg::PIXEL_COUNT,
  parameter int FCNT_W      = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              screen_end,
  output logic [SEL_W-1:0]  boid_sel,
  input  logic [ADDR_W-1:0] boid_addr,
  output logic              disp_clear,
  output logic              disp_we,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              buf_sel,
  input  logic              cpu_wr_req,
  output logic              cpu_wr_grant,
  output logic              cpu_hold,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_count
);
  import boid_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BOIDS - 1);
  localparam logic [ADDR_W:0]  PIX_LIM  = (ADDR_W + 1)'(PIXEL_COUNT);

  sched_state_t state;
  logic         in_range;

  assign in_range     = {1'b0, boid_addr} < PIX_LIM;
  assign cpu_wr_grant = cpu_wr_req & ~cpu_hold;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      boid_sel    <= '0;
      disp_clear  <= 1'b0;
      disp_we     <= 1'b0;
      disp_addr   <= '0;
      cpu_hold    <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      disp_clear <= 1'b0;
      disp_we    <= 1'b0;
      // a frame pulse while busy is dropped, only flagged
      if (screen_end && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (screen_end) begin
            state      <= CLEAR;
            disp_clear <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= SCAN;
          boid_sel <= '0;
        end
        SCAN: begin
          disp_addr <= boid_addr;
          disp_we   <= in_range;
          if (boid_sel == LAST_SEL) begin
            boid_sel <= '0;
            state    <= DRAIN;
          end else begin
            boid_sel <= boid_sel + 1'b1;
          end
        end
        DRAIN: begin
          state       <= IDLE;
          cpu_hold    <= 1'b0;
          frame_count <= frame_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOID_SCHED_DOUBLE_BUFFER_EN
  logic buf_q;

  always_ff @(posedge clock) begin
    if (!resetn)
      buf_q <= 1'b0;
    else if (state == IDLE && screen_end)
      buf_q <= ~buf_q;
  end

  assign buf_sel = buf_q;
`else
  assign buf_sel = 1'b0;
`endif

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Bench for boid_frame_scheduler: frame-timeline reference model,
// directed scenarios and randomized frames/resets/CPU requests.
module tb_boid_frame_scheduler;
  localparam int N   = 16;
  localparam int AW  = 19;
  localparam int PIX = 307200;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          screen_end = 1'b0;
  logic          cpu_wr_req = 1'b0;
  logic [3:0]    boid_sel;
  logic [AW-1:0] boid_addr;
  logic          disp_clear;
  logic          disp_we;
  logic [AW-1:0] disp_addr;
  logic          buf_sel;
  logic          cpu_wr_grant;
  logic          cpu_hold;
  logic          overrun;
  logic [15:0]   frame_count;

  logic [AW-1:0] tab [N];

  always #5 clock = ~clock;

  assign boid_addr = tab[boid_sel];

  boid_frame_scheduler dut (
    .clock       (clock),
    .resetn      (resetn),
    .screen_end  (screen_end),
    .boid_sel    (boid_sel),
    .boid_addr   (boid_addr),
    .disp_clear  (disp_clear),
    .disp_we     (disp_we),
    .disp_addr   (disp_addr),
    .buf_sel     (buf_sel),
    .cpu_wr_req  (cpu_wr_req),
    .cpu_wr_grant(cpu_wr_grant),
    .cpu_hold    (cpu_hold),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  int n_chk = 0;
  int n_bad = 0;

  // frame model: k counts edges since the accepted pulse
  bit            busy;
  int            k;
  bit            m_ovr;
  int            m_fc;
  bit            m_buf;
  int            m_addr;
  int            nclr;
  int            nhold;
  int            nlow;
  logic [AW-1:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s @%0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit se, input bit req, input bit rn);
    bit exp_we;
    int exp_sel;
    screen_end = se;
    cpu_wr_req = req;
    resetn     = rn;
    @(posedge clock);
    if (!rn) begin
      busy   = 0;
      k      = 0;
      m_ovr  = 0;
      m_fc   = 0;
      m_buf  = 0;
      m_addr = 0;
    end else if (!busy) begin
      if (se) begin
        busy = 1;
        k    = 1;
`ifdef BOID_SCHED_DOUBLE_BUFFER_EN
        m_buf = ~m_buf;
`endif
      end
    end else begin
      if (se) m_ovr = 1;
      k++;
      if (k >= 3 && k <= N + 2) m_addr = int'(tab[k-3]);
      if (k == N + 3) begin
        busy = 0;
        k    = 0;
        m_fc = (m_fc + 1) % 65536;
      end
    end
    @(negedge clock);
    exp_we = 0;
    if (busy && k >= 3 && k <= N + 2)
      exp_we = int'(tab[k-3]) < PIX;
    exp_sel = (busy && k >= 2 && k <= N + 1) ? k - 2 : 0;
    chk("hold",  32'(cpu_hold),     32'(busy));
    chk("clear", 32'(disp_clear),   32'(busy && k == 1));
    chk("sel",   32'(boid_sel),     32'(exp_sel));
    chk("we",    32'(disp_we),      32'(exp_we));
    chk("addr",  32'(disp_addr),    32'(m_addr));
    chk("grant", 32'(cpu_wr_grant), 32'(req && !busy));
    chk("ovr",   32'(overrun),      32'(m_ovr));
    chk("fcnt",  32'(frame_count),  32'(m_fc));
    chk("buf",   32'(buf_sel),      32'(m_buf));
    if (disp_we === 1'b1) wq.push_back(disp_addr);
    if (disp_clear === 1'b1) nclr++;
    if (cpu_hold === 1'b1) nhold++;
    if (cpu_wr_grant === 1'b0) nlow++;
  endtask

  task automatic frame(input bit req);
    step(1'b1, req, 1'b1);
    repeat (N + 3) step(1'b0, req, 1'b1);
  endtask

  task automatic clr_stats();
    wq.delete();
    nclr  = 0;
    nhold = 0;
    nlow  = 0;
  endtask

  initial begin
    int fc0;
    logic [31:0] bufs [3];
    logic [31:0] r;
    for (int i = 0; i < N; i++) tab[i] = AW'(6410 + 641 * i);

    // reset then idle
    repeat (3) step(1'b0, 1'b0, 1'b0);
    clr_stats();
    repeat (50) step(1'b0, 1'b0, 1'b1);
    chk("t1_nclr", 32'(nclr), 0);
    chk("t1_nwr", 32'(wq.size()), 0);

    // full frame
    clr_stats();
    frame(1'b0);
    chk("t2_nclr", 32'(nclr), 1);
    chk("t2_nhold", 32'(nhold), 18);
    chk("t2_nwr", 32'(wq.size()), 16);
    for (int i = 0; i < N; i++)
      if (i < wq.size()) chk("t2_wa", 32'(wq[i]), 32'(6410 + 641 * i));
    chk("t2_fc", 32'(frame_count), 1);

    // range skip
    tab[5] = AW'(307200);
    tab[6] = AW'(307199);
    clr_stats();
    frame(1'b0);
    chk("t3_nwr", 32'(wq.size()), 15);
    if (wq.size() > 5) chk("t3_w5", 32'(wq[5]), 307199);

    // overrun
    fc0 = int'(frame_count);
    clr_stats();
    step(1'b1, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    chk("t4_ovr", 32'(overrun), 1);
    chk("t4_fc", 32'(frame_count), 32'(fc0 + 1));
    chk("t4_nwr", 32'(wq.size()), 15);
    frame(1'b0);
    chk("t4_ovr2", 32'(overrun), 1);
    chk("t4_fc2", 32'(frame_count), 32'(fc0 + 2));

    // CPU arbitration
    step(1'b0, 1'b1, 1'b1);
    clr_stats();
    frame(1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("t5_nlow", 32'(nlow), 18);

    // reset mid-scan, then three frames
    step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    clr_stats();
    repeat (20) step(1'b0, 1'b0, 1'b1);
    chk("t6_nwr", 32'(wq.size()), 0);
    chk("t6_buf", 32'(buf_sel), 0);
    chk("t6_ovr", 32'(overrun), 0);
    for (int f = 0; f < 3; f++) begin
      step(1'b1, 1'b0, 1'b1);
      bufs[f] = 32'(buf_sel);
      repeat (N + 3) step(1'b0, 1'b0, 1'b1);
    end
`ifdef BOID_SCHED_DOUBLE_BUFFER_EN
    chk("t6_b0", bufs[0], 1);
    chk("t6_b1", bufs[1], 0);
    chk("t6_b2", bufs[2], 1);
`else
    chk("t6_b0", bufs[0], 0);
    chk("t6_b1", bufs[1], 0);
    chk("t6_b2", bufs[2], 0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!busy && ($urandom % 16) == 0) begin
        for (int i = 0; i < N; i++) begin
          r = $urandom % 8;
          if (r == 0)
            tab[i] = AW'(PIX + $urandom % ((1 << AW) - PIX));
          else if (r == 1)
            tab[i] = AW'(PIX - 1);
          else if (r == 2)
            tab[i] = AW'(PIX);
          else
            tab[i] = AW'($urandom % PIX);
        end
      end
      step(($urandom % 8) == 0, $urandom % 2 == 1,
           ($urandom % 300) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/boid_frame_scheduler.md
# boid_frame_scheduler

- Sequences the per-frame rebuild of the boid display memory.
- On each end-of-screen pulse from the VGA controller it:
  - issues a one-cycle clear to the display RAM;
  - walks every BPU through the boid read-select bus;
  - writes each valid boid pixel address into the display RAM.
- It also holds off CPU position writes while the scan is in progress, so a frame never mixes old and new positions.
- Sits between the BPU array, the CPU position-write decoder and the resettable display RAM, all on the 50 MHz processor clock.

## Interface

Parameters:
- NUM_BOIDS, 16, number of BPUs scanned per frame (≥2).
- SEL_W, $clog2(NUM_BOIDS), width of boid select.
- ADDR_W, 19, display RAM address width.
- PIXEL_COUNT, 307200, number of valid pixel addresses (640×480).
- FCNT_W, 16, frame counter width.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clock  in  1  processor clock.
  - resetn  in  1  synchronous active-low reset.
- VGA side:
  - screen_end  in  1  end-of-frame pulse from the VGA controller.
- BPU side:
  - boid_sel  out  SEL_W  index of the BPU currently being read.
  - boid_addr  in  ADDR_W  pixel address of the selected BPU (combinational from the BPU mux).
- Display RAM side:
  - disp_clear  out  1  one-cycle clear/switch pulse to the display RAM.
  - disp_we  out  1  display RAM write enable (write data is implicitly 1).
  - disp_addr  out  ADDR_W  display RAM write address.
  - buf_sel  out  1  display buffer currently being written.
- CPU side:
  - cpu_wr_req  in  1  CPU requests a BPU position write.
  - cpu_wr_grant  out  1  `cpu_wr_req & ~cpu_hold`, combinational.
  - cpu_hold  out  1  high while the scheduler is busy.
- Status:
  - overrun  out  1  sticky; set when a frame pulse arrives while busy.
  - frame_count  out  FCNT_W  number of completed scans.

## Operation

- States are IDLE, CLEAR, SCAN and DRAIN.
- IDLE:
  - If screen_end is sampled high, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle):
  - disp_clear = 1.
  - Index counter loads 0.
  - With the double-buffer option compiled in, buf_sel toggles on entry.
  - Next state is SCAN.
- SCAN (NUM_BOIDS cycles):
  - boid_sel = index.
  - At the end of each cycle, boid_addr is registered into disp_addr.
  - disp_we for that slot is set to `boid_addr < PIXEL_COUNT`. Out-of-range addresses are silently skipped.
  - The index increments each cycle.
  - After index NUM_BOIDS-1, go to DRAIN.
- DRAIN (1 cycle):
  - The last registered write is presented.
  - frame_count increments, wrapping modulo 2^FCNT_W.
  - Next state is IDLE.
- cpu_hold = 1 in CLEAR, SCAN and DRAIN; 0 in IDLE.
  - The CPU decoder must gate its BPU write enable with cpu_wr_grant.
  - Held requests are not queued; the CPU side retries.
- screen_end sampled in CLEAR, SCAN or DRAIN:
  - The pulse is ignored, with no restart.
  - overrun is set to 1 and stays set until reset.
- screen_end high in IDLE is accepted, including the first cycle after DRAIN.
- A level-high screen_end restarts a scan immediately after each DRAIN, and sets overrun during every scan it overlaps.
- boid_sel holds 0 outside SCAN.

## Timing

- Reset values (all outputs return to these the cycle after resetn is sampled low, including mid-scan; a partial frame is abandoned and no further writes are issued):
  - state = IDLE.
  - boid_sel = 0, disp_clear = 0, disp_we = 0, disp_addr = 0, buf_sel = 0.
  - cpu_hold = 0, overrun = 0, frame_count = 0.
- Frame timeline, with screen_end sampled at edge T0:
  - T1: disp_clear = 1.
  - T2 … T(N+1): boid_sel = 0 … N-1.
  - T3 … T(N+2): disp_we/disp_addr for boid 0 … N-1.
  - T(N+2): DRAIN.
  - T(N+3): IDLE.
- Total busy time is N+2 cycles; 18 for N=16.
- Write latency is one cycle from boid_sel to the corresponding disp_addr.
- disp_clear never coincides with disp_we.

## Configuration

- Macro: BOID_SCHED_DOUBLE_BUFFER_EN.
- Defined:
  - buf_sel toggles on every CLEAR entry.
  - The display RAM clears and writes the buffer selected by buf_sel; the VGA reads the other one.
- Undefined:
  - buf_sel is tied to 0.
  - The single buffer is cleared in place.
  - All other behaviour is identical.

## Structure

- Shared package boid_pkg holds:
  - the state enum (IDLE, CLEAR, SCAN, DRAIN);
  - the VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_COUNT and MAX_BOIDS constants;
  - the pixel address width.
- Single flat module; no sub-module is warranted.

## Test plan

1. Reset then idle:
   - Stimulus: hold resetn=0 for 3 cycles, then release with screen_end=0 for 50 cycles.
   - Required: all outputs 0 throughout, frame_count=0.
2. Full frame, N=16:
   - Stimulus: boid_addr = 6410 + 641·boid_sel, one screen_end pulse.
   - Required:
     - disp_clear exactly once.
     - 16 writes at addresses 6410, 7051, …, 16025 in order.
     - cpu_hold high for 18 cycles.
     - frame_count=1.
3. Range skip:
   - Stimulus: boid 5 reports 307200; boid 6 reports 307199.
   - Required: slot 5 has disp_we=0; slot 6 writes 307199; 15 writes in total.
4. Overrun:
   - Stimulus: second screen_end at T8 of a scan.
   - Required: scan completes unchanged, overrun=1, frame_count=1.
   - Follow-up: a pulse in IDLE starts a new scan; overrun stays 1.
5. CPU arbitration:
   - Stimulus: cpu_wr_req held high across a frame.
   - Required: cpu_wr_grant=0 exactly in T1…T18, and 1 otherwise.
6. Reset mid-scan and double buffering:
   - Reset mid-scan stimulus: resetn=0 at T7.
   - Reset mid-scan required: disp_we=0 from T8 onward, state returns to IDLE, buf_sel=0.
   - Double-buffer stimulus: 3 frames with BOID_SCHED_DOUBLE_BUFFER_EN defined.
   - Double-buffer required: buf_sel goes 1, 0, 1.
